spu_fetch: RTL

SPU_FETCH -- requirements
Module: spu_fetch

---
 rtl/spu_fetch.sv | 107 ++++++++++
 1 files changed

// File: rtl/spu_fetch.sv
// spu_fetch: SPU instruction fetch with a credit-limited instruction queue.
// Ports: clk/reset_n; local-store read (memread/adr/memdata, ls_busy);
//        redirect/redirect_pc; decode handshake (inst_valid/inst/inst_pc/inst_ready).
module spu_fetch #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             memread,
    output logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] memdata,
    input  logic             ls_busy,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             inst_valid,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    input  logic             inst_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] inflight_pc;
    logic             inflight;

    logic [WIDTH-1:0] q_inst [DEPTH];
    logic [WIDTH-1:0] q_pc   [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;

    logic [AW+1:0]    credit;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] redir_base;
    logic             unused_bits;

    // Slots already promised = queued entries plus the read in flight.
    assign credit = {1'b0, count} + {{(AW + 1){1'b0}}, inflight};

    assign memread = reset_n && !ls_busy && !redirect
                   && (credit < (AW + 2)'(DEPTH));
    assign adr     = fetch_pc;

    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? q_inst[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? q_pc[rd_ptr]   : '0;

    // Redirect kills both the returning word and the head pop.
    assign push = inflight && !redirect;
    assign pop  = inst_valid && inst_ready && !redirect;

    // Fetch PC wraps inside the 16 KB local store.
    always_comb begin
        pc_next             = '0;
        pc_next[13:0]       = fetch_pc[13:0] + 14'd4;
        redir_base          = '0;
        redir_base[13:2]    = redirect_pc[13:2];
    end

    assign unused_bits = ^{redirect_pc[WIDTH-1:14], redirect_pc[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            fetch_pc    <= redir_base;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (memread) begin
                fetch_pc    <= pc_next;
                inflight_pc <= fetch_pc;
                inflight    <= 1'b1;
            end else begin
                inflight    <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset: reads are masked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= memdata;
            q_pc[wr_ptr]   <= inflight_pc;
        end
    end

endmodule
